// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator: pixel/line counters plus sync, blank and frame decode.
// Latency: hs/vs/blank/frame_start are registered and aligned with DrawX/DrawY; there is no decode lag.
// Backpressure: none. The generator runs freely on every vga_clk edge once reset is released.
//
// Ports:
//   vga_clk     in   pixel clock (25 MHz nominal); all state changes on its rising edge
//   reset       in   synchronous, active-high
//   hs, vs      out  horizontal / vertical sync, active-low
//   blank       out  1 while the current pixel lies in the visible area
//   sync        out  composite sync for the DAC, tied to 0
//   DrawX       out  pixel counter within the line (0 .. H_TOTAL-1)
//   DrawY       out  line counter within the frame (0 .. V_TOTAL-1)
//   frame_start out  high for the single cycle where DrawX=0 and DrawY=0
//   frame_cnt   out  completed frames modulo 256
//
// Build option: define VGA_FRAME_COUNT_EN to enable the frame counter.
// Without it, frame_cnt is tied to 8'h00 and no counter flops are built.
//
// The timing parameters default to the 640x480 mode. Smaller values are
// only useful for exercising the frame-level behaviour in short runs.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    // Decode boundaries as 10-bit constants so every compare is width-matched.
    localparam logic [9:0] H_VIS_LAST   = 10'(H_VISIBLE - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_LAST   = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    // run_q is clear for the first edge after reset. That edge presents pixel
    // (0,0) with its real decode (blank=1, frame_start=1) rather than advancing
    // the counters. From then on the counters advance every clock.
    logic       run_q;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       fs_q, fs_d;

    // Next counter position. The wrap values are compared exactly, so the
    // counters never hold a value beyond the last pixel or line.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!run_q) begin
            x_d = 10'd0;
            y_d = 10'd0;
        end else if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            x_d = x_q + 10'd1;
        end
    end

    // Decode from the next counter values. The registered outputs therefore
    // line up with the counter values they are registered alongside.
    always_comb begin
        hs_d    = !((x_d >= H_SYNC_FIRST) && (x_d <= H_SYNC_LAST));
        vs_d    = !((y_d >= V_SYNC_FIRST) && (y_d <= V_SYNC_LAST));
        blank_d = (x_d <= H_VIS_LAST) && (y_d <= V_VIS_LAST);
        fs_d    = (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // A frame completes on the clock where the last pixel of the last line
    // wraps to (0,0). The restart out of reset does not count as a frame.
    logic       frame_wrap;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign frame_wrap = run_q && (x_q == H_LAST) && (y_q == V_LAST);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'h00;
`endif

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// u_dut uses the 640x480 timing and covers reset, line timing, a long run and a mid-line reset.
// u_small uses a 20x7 raster to cover frame-level behaviour within a short run.
module tb_vga_timing_gen;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       reset_s = 1'b1;

    logic       hs, vs, blank, sync, frame_start;
    logic [9:0] DrawX, DrawY;
    logic [7:0] frame_cnt;

    logic       hs_s, vs_s, blank_s, sync_s, frame_start_s;
    logic [9:0] DrawX_s, DrawY_s;
    logic [7:0] frame_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .hs         (hs),
        .vs         (vs),
        .blank      (blank),
        .sync       (sync),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frame_start(frame_start),
        .frame_cnt  (frame_cnt)
    );

    // Small raster: 8 visible + 2 front porch + 4 sync + 6 back porch = 20 clocks per line.
    // Hsync covers x = 10..13.
    // 3 visible + 1 front porch + 2 sync + 1 back porch = 7 lines per frame, 140 clocks per frame.
    // Vsync covers lines 4..5.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(6),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .vga_clk    (vga_clk),
        .reset      (reset_s),
        .hs         (hs_s),
        .vs         (vs_s),
        .blank      (blank_s),
        .sync       (sync_s),
        .DrawX      (DrawX_s),
        .DrawY      (DrawY_s),
        .frame_start(frame_start_s),
        .frame_cnt  (frame_cnt_s)
    );

    // Packed view of the main DUT outputs: {DrawX, DrawY, hs, vs, blank, frame_start, sync}.
    logic [24:0] obs_m;
    assign obs_m = {DrawX, DrawY, hs, vs, blank, frame_start, sync};
    logic [24:0] obs_s;
    assign obs_s = {DrawX_s, DrawY_s, hs_s, vs_s, blank_s, frame_start_s, sync_s};

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge vga_clk);
        n_tests++;
        if (obs_m !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", obs_m, {10'd0, 10'd0, 5'b11000});
        end
        n_tests++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt);
        end
        reset = 1'b0;
        @(negedge vga_clk);
        n_tests++;
        if (obs_m !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL first_after_reset got=%h want=%h", obs_m, {10'd0, 10'd0, 5'b11110});
        end
    endtask

    // Starts on the first post-reset cycle (0,0) and walks one full line.
    task automatic test_line();
        int          hs_low = 0;
        int          blank_off_at = -1;
        logic [24:0] exp;
        for (int i = 0; i < 800; i++) begin
            exp = {10'(i), 10'd0, !((i >= 656) && (i <= 751)), 1'b1, (i < 640), (i == 0), 1'b0};
            n_tests++;
            if (obs_m !== exp) begin
                n_fail++;
                $display("FAIL line0_x%0d got=%h want=%h", i, obs_m, exp);
            end
            if (hs === 1'b0) hs_low++;
            if ((blank === 1'b0) && (blank_off_at < 0)) blank_off_at = i;
            @(negedge vga_clk);
        end
        n_tests++;
        if (hs_low != 96) begin
            n_fail++;
            $display("FAIL hs_low_width got=%0d want=96", hs_low);
        end
        n_tests++;
        if (blank_off_at != 640) begin
            n_fail++;
            $display("FAIL blank_fall_x got=%0d want=640", blank_off_at);
        end
        n_tests++;
        if ({DrawX, DrawY, frame_start} !== {10'd0, 10'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL line_wrap got x=%0d y=%0d fs=%b want x=0 y=1 fs=0", DrawX, DrawY, frame_start);
        end
    endtask

    // Independent position model compared against every output, each cycle, for 20 lines.
    task automatic test_continuous();
        int          ex = 0;
        int          ey = 1;
        logic [24:0] exp;
        for (int c = 0; c < 16000; c++) begin
            exp = {10'(ex), 10'(ey), !((ex >= 656) && (ex <= 751)), !((ey == 490) || (ey == 491)),
                   ((ex < 640) && (ey < 480)), ((ex == 0) && (ey == 0)), 1'b0};
            n_tests++;
            if ((obs_m !== exp) || (DrawX >= 10'd800) || (DrawY >= 10'd525)) begin
                n_fail++;
                $display("FAIL continuous_c%0d got=%h want=%h", c, obs_m, exp);
            end
            ex++;
            if (ex == 800) begin
                ex = 0;
                ey = (ey == 524) ? 0 : ey + 1;
            end
            @(negedge vga_clk);
        end
    endtask

    task automatic test_midline_reset();
        int waited = 0;
        while ((DrawX !== 10'd700) && (waited < 900)) begin
            @(negedge vga_clk);
            waited++;
        end
        n_tests++;
        if ((DrawX !== 10'd700) || (hs !== 1'b0)) begin
            n_fail++;
            $display("FAIL midline_reach got x=%0d hs=%b want x=700 hs=0", DrawX, hs);
        end
        reset = 1'b1;
        @(negedge vga_clk);
        n_tests++;
        if (obs_m !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midline_reset got=%h want=%h", obs_m, {10'd0, 10'd0, 5'b11000});
        end
        @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        n_tests++;
        if (obs_m !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midline_restart got=%h want=%h", obs_m, {10'd0, 10'd0, 5'b11110});
        end
    endtask

    task automatic test_small_frame();
        int          vs_low = 0;
        int          blank_hi = 0;
        int          fs_cnt = 0;
        int          ex = 0;
        int          ey = 0;
        logic [24:0] exp;
        reset_s = 1'b1;
        repeat (3) @(negedge vga_clk);
        n_tests++;
        if ({obs_s, frame_cnt_s} !== {10'd0, 10'd0, 5'b11000, 8'd0}) begin
            n_fail++;
            $display("FAIL small_reset got=%h cnt=%0d want=%h cnt=0", obs_s, frame_cnt_s, {10'd0, 10'd0, 5'b11000});
        end
        reset_s = 1'b0;
        @(negedge vga_clk);
        for (int c = 0; c < 140; c++) begin
            exp = {10'(ex), 10'(ey), !((ex >= 10) && (ex <= 13)), !((ey == 4) || (ey == 5)),
                   ((ex < 8) && (ey < 3)), ((ex == 0) && (ey == 0)), 1'b0};
            n_tests++;
            if (obs_s !== exp) begin
                n_fail++;
                $display("FAIL small_frame_c%0d got=%h want=%h", c, obs_s, exp);
            end
            if (vs_s === 1'b0) vs_low++;
            if (blank_s === 1'b1) blank_hi++;
            if (frame_start_s === 1'b1) fs_cnt++;
            ex++;
            if (ex == 20) begin
                ex = 0;
                ey = (ey == 6) ? 0 : ey + 1;
            end
            @(negedge vga_clk);
        end
        n_tests++;
        if (vs_low != 40) begin
            n_fail++;
            $display("FAIL small_vs_low got=%0d want=40", vs_low);
        end
        n_tests++;
        if (blank_hi != 24) begin
            n_fail++;
            $display("FAIL small_blank_hi got=%0d want=24", blank_hi);
        end
        n_tests++;
        if (fs_cnt != 1) begin
            n_fail++;
            $display("FAIL small_fs_count got=%0d want=1", fs_cnt);
        end
        n_tests++;
        if ({DrawX_s, DrawY_s, frame_start_s} !== {10'd0, 10'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL small_fs_period got x=%0d y=%0d fs=%b want 0 0 1", DrawX_s, DrawY_s, frame_start_s);
        end
    endtask

    task automatic test_small_midframe_reset();
        int waited = 0;
        while (!((DrawX_s === 10'd12) && (DrawY_s === 10'd5)) && (waited < 300)) begin
            @(negedge vga_clk);
            waited++;
        end
        n_tests++;
        if ({DrawX_s, DrawY_s, hs_s, vs_s} !== {10'd12, 10'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL small_mid_reach got x=%0d y=%0d hs=%b vs=%b want 12 5 0 0", DrawX_s, DrawY_s, hs_s, vs_s);
        end
        reset_s = 1'b1;
        @(negedge vga_clk);
        n_tests++;
        if (obs_s !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL small_mid_reset got=%h want=%h", obs_s, {10'd0, 10'd0, 5'b11000});
        end
        @(negedge vga_clk);
    endtask

    task automatic test_frame_cnt();
        reset_s = 1'b0;
        @(negedge vga_clk);
        n_tests++;
        if ({DrawX_s, DrawY_s, frame_start_s, frame_cnt_s} !== {10'd0, 10'd0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL cnt_start got x=%0d y=%0d fs=%b cnt=%0d want 0 0 1 0", DrawX_s, DrawY_s, frame_start_s, frame_cnt_s);
        end
`ifdef VGA_FRAME_COUNT_EN
        repeat (139) @(negedge vga_clk);
        n_tests++;
        if (frame_cnt_s !== 8'd0) begin
            n_fail++;
            $display("FAIL cnt_last_pixel got=%0d want=0", frame_cnt_s);
        end
        @(negedge vga_clk);
        n_tests++;
        if (frame_cnt_s !== 8'd1) begin
            n_fail++;
            $display("FAIL cnt_first_wrap got=%0d want=1", frame_cnt_s);
        end
        repeat (140 * 254) @(negedge vga_clk);
        n_tests++;
        if (frame_cnt_s !== 8'd255) begin
            n_fail++;
            $display("FAIL cnt_255 got=%0d want=255", frame_cnt_s);
        end
        repeat (140) @(negedge vga_clk);
        n_tests++;
        if (frame_cnt_s !== 8'd0) begin
            n_fail++;
            $display("FAIL cnt_wrap0 got=%0d want=0", frame_cnt_s);
        end
        repeat (140) @(negedge vga_clk);
        n_tests++;
        if (frame_cnt_s !== 8'd1) begin
            n_fail++;
            $display("FAIL cnt_wrap1 got=%0d want=1", frame_cnt_s);
        end
`else
        begin
            int nonzero = 0;
            for (int c = 0; c < 420; c++) begin
                @(negedge vga_clk);
                if (frame_cnt_s !== 8'd0) nonzero++;
            end
            n_tests++;
            if (nonzero != 0) begin
                n_fail++;
                $display("FAIL cnt_tied_off got=%0d nonzero cycles want=0 (last=%0d)", nonzero, frame_cnt_s);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_line();
        test_continuous();
        test_midline_reset();
        test_small_frame();
        test_small_midframe_reset();
        test_frame_cnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 vga_clk  input  1  pixel clock, 25 MHz nominal; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 hs  output  1  horizontal sync, active-low.
REQ-004 vs  output  1  vertical sync, active-low.
REQ-005 blank  output  1  display-enable: 1 = pixel in 640x480 visible area, 0 = blanking (downstream mappers drive colour only when 1).
REQ-006 sync  output  1  composite sync for the DAC, constant 0.
REQ-007 DrawX  output  10  current horizontal pixel counter, 0..799.
REQ-008 DrawY  output  10  current line counter, 0..524.
REQ-009 frame_start  output  1  one-cycle pulse while DrawX=0 and DrawY=0.
REQ-010 frame_cnt  output  8  frames completed, modulo 256 (see Configuration).

Function
REQ-011 Horizontal timing SHALL be 640 visible + 16 front porch + 96 sync + 48 back porch = 800 clocks per line.
REQ-012 Vertical timing SHALL be 480 visible + 10 front porch + 2 sync + 33 back porch = 525 lines per frame.
REQ-013 DrawX SHALL increment by 1 each clock and wrap 799 -> 0.
REQ-014 DrawY SHALL increment by 1 only in the clock where DrawX wraps 799 -> 0; DrawY wraps 524 -> 0 in that same clock.
REQ-015 hs SHALL be 0 exactly when 656 <= DrawX <= 751, else 1.
REQ-016 vs SHALL be 0 exactly when DrawY is 490 or 491, else 1.
REQ-017 blank SHALL be 1 exactly when DrawX <= 639 and DrawY <= 479.
REQ-018 hs, vs, blank and frame_start SHALL be registered outputs that are cycle-aligned with the DrawX/DrawY values presented in the same cycle; zero decode latency relative to the counters.
REQ-019 frame_start SHALL pulse for exactly one clock per 420000 clocks in free-running operation.
REQ-020 Counter arithmetic SHALL be 10-bit unsigned; no intermediate state may expose DrawX >= 800 or DrawY >= 525.

Reset
REQ-021 While reset=1 at a clock edge: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, frame_cnt=0.
REQ-022 First clock after reset deasserts: DrawX=0, DrawY=0, blank=1, frame_start=1; counting proceeds per REQ-013.
REQ-023 Reset asserted mid-line or mid-frame (including during hs/vs low) SHALL abort the frame and apply REQ-021 at the next edge; no partial pulse persists.

Configuration
REQ-024 Macro VGA_FRAME_COUNT_EN SHALL control the frame counter.
REQ-025 With VGA_FRAME_COUNT_EN defined: frame_cnt increments by 1 in the clock where DrawY wraps 524 -> 0, wrapping 255 -> 0.
REQ-026 Without VGA_FRAME_COUNT_EN: port frame_cnt present, tied to 8'h00, no counter flops synthesised.

Verification
REQ-027 Release reset after 3 clocks -> first post-reset cycle DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1.
REQ-028 Run 800 clocks from DrawX=0 -> blank falls when DrawX=640; hs=0 for DrawX 656..751 (96 clocks); DrawX=799 then 0 with DrawY=1.
REQ-029 Run one full frame -> vs=0 for exactly 1600 clocks (lines 490-491); blank=1 for exactly 307200 clocks; next frame_start 420000 clocks after previous.
REQ-030 Assert reset at DrawX=700, DrawY=491 (hs=0, vs=0) -> next edge hs=1, vs=1, DrawX=0, DrawY=0, blank=0.
REQ-031 With VGA_FRAME_COUNT_EN, run 257 frames -> frame_cnt reaches 255 then wraps to 0, then 1; without macro frame_cnt stays 0 throughout.
REQ-032 Continuous check over 2 frames: sync=0 always; DrawX<800, DrawY<525 every cycle; blank==(DrawX<640 && DrawY<480) every cycle.
